// File: rtl/magic_round_sched.sv
// magic_round_sched
//   Iterative round scheduler that reuses a single external "magic" stage for
//   every round of the chained transform. An accepted operand is issued to the
//   magic stage NUM_ROUNDS times; round k uses key bits [2k+1:2k] of the
//   original operand as the selector, and each result becomes the next operand.
//
//   Optional build macro: MAGIC_SCHED_STATS_EN adds the ops_done and
//   busy_cycles statistics ports (saturating counters).
//
//   Handshake rules (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both high. in_ready is high only in IDLE.
//   out_valid, once high, holds with out_data stable until out_ready, unless
//   abort cancels the operation. abort in IDLE is ignored.
module magic_round_sched #(
    parameter int DATA_W    = 8,
    parameter int MAGIC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic [DATA_W-1:0] m_inp,
    output logic [1:0]        m_val,
    output logic              m_start,
    input  logic [DATA_W-1:0] m_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef MAGIC_SCHED_STATS_EN
    ,
    output logic [15:0]       ops_done,
    output logic [31:0]       busy_cycles
`endif
);

    localparam int NUM_ROUNDS = DATA_W / 2;
    localparam int RND_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam int CNT_W      = (MAGIC_LAT > 2) ? $clog2(MAGIC_LAT) : 1;
    localparam int LAST_WAIT  = (MAGIC_LAT > 0) ? MAGIC_LAT - 1 : 0;

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(LAST_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [RND_W-1:0]  round;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] result;
    logic              round_end;

    // Last cycle of the current round: the ISSUE cycle itself for a
    // combinational magic stage, otherwise the final WAIT cycle.
    always_comb begin
        round_end = 1'b0;
        if (state == S_ISSUE && MAGIC_LAT == 0) begin
            round_end = 1'b1;
        end
        if (state == S_WAIT && wait_cnt == LAST_CNT) begin
            round_end = 1'b1;
        end
    end

    // Main FSM: accept, issue/wait per round, capture result, present output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            round    <= '0;
            wait_cnt <= '0;
            acc      <= '0;
            key      <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc      <= in_data;
                        key      <= in_data;
                        round    <= '0;
                        wait_cnt <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (round_end) begin
                        // m_res is only meaningful on this cycle.
                        acc <= m_res;
                        if (round == LAST_ROUND) begin
                            result <= m_res;
                            state  <= S_DONE;
                        end else begin
                            round <= round + RND_W'(1);
                            state <= S_ISSUE;
                        end
                    end else if (state == S_ISSUE) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // abort and out_ready both return to IDLE; abort simply
                    // means the result is not counted as delivered.
                    if (abort || out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Round key selection: two key bits per round, chosen by the round index.
    always_comb begin
        m_val = 2'b00;
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            if (round == RND_W'(r)) begin
                m_val = key[2*r +: 2];
            end
        end
    end

    // Output decode; everything derives from async-reset state so a reset
    // mid-operation drops m_start and out_valid immediately.
    always_comb begin
        in_ready  = (state == S_IDLE);
        m_start   = (state == S_ISSUE);
        m_inp     = acc;
        out_valid = (state == S_DONE);
        out_data  = result;
        busy      = (state != S_IDLE);
    end

`ifdef MAGIC_SCHED_STATS_EN
    // Saturating statistics: delivered results and busy cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_done    <= '0;
            busy_cycles <= '0;
        end else begin
            if (state == S_DONE && out_ready && !abort && ops_done != 16'hFFFF) begin
                ops_done <= ops_done + 16'd1;
            end
            if (busy && busy_cycles != 32'hFFFF_FFFF) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_magic_round_sched.sv
// tb_magic_round_sched
//   Drives magic_round_sched with directed and random operands, models the
//   magic stage as m_res = m_inp ^ {DATA_W/2{m_val}} delayed MAGIC_LAT cycles,
//   and compares results, issue sequences and timing with a reference model.
//   Inputs change 1 time unit after the rising edge; outputs are read there
//   or on the falling edge.
module tb_magic_round_sched;

    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int NR  = W / 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         abort;
    logic [W-1:0] m_inp;
    logic [1:0]   m_val;
    logic         m_start;
    logic [W-1:0] m_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
`ifdef MAGIC_SCHED_STATS_EN
    logic [15:0]  ops_done;
    logic [31:0]  busy_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;

    logic [W-1:0]   exp_q[$];
    logic [W+1:0]   obs_q[$];
    logic [W+1:0]   exp_seq[$];

    magic_round_sched #(.DATA_W(W), .MAGIC_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .m_inp     (m_inp),
        .m_val     (m_val),
        .m_start   (m_start),
        .m_res     (m_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MAGIC_SCHED_STATS_EN
        ,
        .ops_done    (ops_done),
        .busy_cycles (busy_cycles)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stub magic stage ----------------
    // Produces the real result only when the issued value is due; junk
    // otherwise so a capture on the wrong cycle is visible.
    logic [W-1:0] stub_f;
    logic [W-1:0] junk;
    assign stub_f = m_inp ^ {NR{m_val}};
    always @(posedge clk) junk <= W'($urandom);

    generate
        if (LAT == 0) begin : g_comb
            assign m_res = m_start ? stub_f : junk;
        end else begin : g_pipe
            logic [W-1:0] pd[LAT];
            logic         pv[LAT];
            always @(posedge clk) begin
                pd[0] <= stub_f;
                pv[0] <= m_start;
                for (int i = 1; i < LAT; i++) begin
                    pd[i] <= pd[i-1];
                    pv[i] <= pv[i-1];
                end
            end
            assign m_res = pv[LAT-1] ? pd[LAT-1] : junk;
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] rep_key(input logic [1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[2*i +: 2] = v;
        return r;
    endfunction

    // Builds the expected issue sequence and returns the final result.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x);
        logic [W-1:0] a;
        logic [1:0]   k;
        a = x;
        exp_seq.delete();
        for (int r = 0; r < NR; r++) begin
            k = x[2*r +: 2];
            exp_seq.push_back({k, a});
            a = a ^ rep_key(k);
        end
        return a;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard/monitor on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_ops = 0;
        end else begin
            if (m_start) obs_q.push_back({m_val, m_inp});
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 1);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    exp_ops++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("wait_in_ready", in_ready, 1);
    endtask

    // Accept one operand; on return we are in the first cycle after accept.
    task automatic launch(input logic [W-1:0] x, input logic abort_on_accept);
        wait_idle();
        obs_q.delete();
        in_valid = 1'b1;
        in_data  = x;
        abort    = abort_on_accept;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] x, input int hold, input logic abort_on_accept);
        int lat;
        logic [W-1:0] exp;
        exp = ref_op(x);
        launch(x, abort_on_accept);
        exp_q.push_back(exp);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("latency", lat, NR * (LAT + 1) + 1);
        // Back-pressure with a competing input offered: nothing may move.
        in_valid = 1'b1;
        in_data  = W'($urandom);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_out_data", out_data, exp);
        check("issue_count", obs_q.size(), NR);
        for (int k = 0; k < NR && k < obs_q.size(); k++) begin
            check($sformatf("m_inp_r%0d", k), obs_q[k][W-1:0], exp_seq[k][W-1:0]);
            check($sformatf("m_val_r%0d", k), obs_q[k][W+1:W], exp_seq[k][W+1:W]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_m_start", m_start, 0);
        check("rst_out_data", out_data, 0);
        check("rst_m_inp", m_inp, 0);
        check("rst_m_val", m_val, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Directed vectors.
        run_op(8'h80, 0, 1'b0);
        run_op(8'h1B, 0, 1'b0);
        run_op(8'h5C, 5, 1'b0);

        // Abort during round 2 WAIT.
        launch(8'hC3, 1'b0);
        for (int i = 0; i < 2 * (LAT + 1) + LAT; i++) tick();
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_out", out_valid, 0);
            tick();
        end
        run_op(8'h80, 1, 1'b0);

        // abort wins over out_ready in DONE.
        launch(8'h37, 1'b0);
        for (int i = 0; i < 200 && !out_valid; i++) tick();
        check("abort_done_valid", out_valid, 1);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_done_out_valid", out_valid, 0);
        check("abort_done_in_ready", in_ready, 1);

        // Reset asserted mid round 1.
        launch(8'h6A, 1'b0);
        for (int i = 0; i < LAT + 1; i++) tick();
        check("pre_rst_m_start", m_start, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_m_start", m_start, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_m_inp", m_inp, 0);
        check("mid_rst_m_val", m_val, 0);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_op(8'hFF, 0, 1'b0);

        // Random operands, random back-pressure, occasional abort on accept.
        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        tick();
        tick();
        check("exp_q_empty", exp_q.size(), 0);
`ifdef MAGIC_SCHED_STATS_EN
        check("ops_done", ops_done, exp_ops);
        check("busy_cycles_nonzero", (busy_cycles != 0), 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
